// File: rtl/uart_instr_loader_pkg.sv
// Shared types and constants for the UART instruction loader and its byte receiver.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_STRETCH,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE      = 8'hA5;
    localparam int         TIMEOUT_MULT   = 16;
    localparam int         BITS_PER_FRAME = 10;

    // Inter-byte silence, in clocks, after which a frame in progress is abandoned.
    function automatic int timeout_cycles(input int clks_per_bit);
        return TIMEOUT_MULT * BITS_PER_FRAME * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_instr_loader_rx.sv
// 8N1 UART byte receiver: 2-FF synchroniser, mid-bit sampling, start-bit glitch rejection.
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o
);

    localparam int              CW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    logic            meta, sync, prev;
    rx_state_t       state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [2:0]      bit_idx, bit_idx_d;
    logic [7:0]      shift, shift_d;
    logic            valid_d, ferr_d;

    assign data_o = shift;

    // NOTE: every register uses <= so all flops update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta        <= 1'b1;
            sync        <= 1'b1;
            prev        <= 1'b1;
            state       <= RX_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            meta        <= rx_i;
            sync        <= meta;
            prev        <= sync;
            state       <= state_d;
            cnt         <= cnt_d;
            bit_idx     <= bit_idx_d;
            shift       <= shift_d;
            valid_o     <= valid_d;
            frame_err_o <= ferr_d;
        end
    end

    // NOTE: each *_d gets a default before the case so no latch is inferred.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt + CW'(1);
        bit_idx_d = bit_idx;
        shift_d   = shift;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev && !sync) state_d = RX_START;
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {sync, shift[7:1]};
                    bit_idx_d = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = sync;
                    ferr_d  = !sync;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_instr_loader.sv
// Loads a checksummed UART program image into instruction SRAM while holding the core in reset.
// Optional inter-byte timeout enabled by defining UART_LOADER_TIMEOUT_EN.
module uart_instr_loader
    import loader_pkg::*;
#(
    parameter int          CLK_FREQ_HZ = 25_000_000,
    parameter int          BAUD        = 115200,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          RST_STRETCH = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        uart_rx_i,
    output logic        req_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    output logic        sel_o,
    output logic        core_rst_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [15:0] word_cnt_o
);

    localparam int            CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int            SW           = $clog2(RST_STRETCH + 1);
    localparam logic [SW-1:0] STRETCH_LAST = SW'(RST_STRETCH - 1);
    localparam logic [16:0]   DEPTH_LIM    = 17'(DEPTH_WORDS);

    logic [7:0] rx_data;
    logic       rx_valid, rx_ferr, timeout;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_i        (uart_rx_i),
        .data_o      (rx_data),
        .valid_o     (rx_valid),
        .frame_err_o (rx_ferr)
    );

    state_t        state, state_d;
    logic [SW-1:0] stretch_cnt, stretch_cnt_d;
    logic [15:0]   len, len_d, word_cnt_d;
    logic [1:0]    byte_pos, byte_pos_d;
    logic [23:0]   low_bytes, low_bytes_d;
    logic [7:0]    csum, csum_d;
    logic [31:0]   addr_d, wdata_d;
    logic          req_d, sel_d, core_rst_d, busy_d, err_d;
    logic [16:0]   n_words;

    assign we_o    = req_o;
    assign n_words = {1'b0, rx_data, len[7:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_STRETCH;
            stretch_cnt <= '0;
            len         <= '0;
            byte_pos    <= '0;
            low_bytes   <= '0;
            csum        <= '0;
            req_o       <= 1'b0;
            addr_o      <= '0;
            wdata_o     <= '0;
            sel_o       <= 1'b0;
            core_rst_o  <= 1'b1;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
            word_cnt_o  <= '0;
        end else begin
            state       <= state_d;
            stretch_cnt <= stretch_cnt_d;
            len         <= len_d;
            byte_pos    <= byte_pos_d;
            low_bytes   <= low_bytes_d;
            csum        <= csum_d;
            req_o       <= req_d;
            addr_o      <= addr_d;
            wdata_o     <= wdata_d;
            sel_o       <= sel_d;
            core_rst_o  <= core_rst_d;
            busy_o      <= busy_d;
            err_o       <= err_d;
            word_cnt_o  <= word_cnt_d;
        end
    end

    always_comb begin
        state_d       = state;
        stretch_cnt_d = stretch_cnt;
        len_d         = len;
        byte_pos_d    = byte_pos;
        low_bytes_d   = low_bytes;
        csum_d        = csum;
        req_d         = 1'b0;
        addr_d        = addr_o;
        wdata_d       = wdata_o;
        sel_d         = sel_o;
        core_rst_d    = core_rst_o;
        busy_d        = busy_o;
        err_d         = err_o;
        word_cnt_d    = word_cnt_o;
        case (state)
            S_IDLE, S_ERR: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d    = S_LEN0;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    sel_d      = 1'b1;
                    core_rst_d = 1'b1;
                    word_cnt_d = '0;
                    csum_d     = '0;
                    byte_pos_d = '0;
                end
            end
            S_LEN0: begin
                if (rx_valid) begin
                    len_d   = {len[15:8], rx_data};
                    state_d = S_LEN1;
                end
            end
            S_LEN1: begin
                if (rx_valid) begin
                    len_d = n_words[15:0];
                    if (n_words == '0)            state_d = S_CSUM;
                    else if (n_words > DEPTH_LIM) state_d = S_ERR;
                    else                          state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    csum_d      = csum ^ rx_data;
                    byte_pos_d  = byte_pos + 2'd1;
                    low_bytes_d = {rx_data, low_bytes[23:8]};
                    if (byte_pos == 2'd3) begin
                        req_d      = 1'b1;
                        addr_d     = BASE_ADDR + {14'd0, word_cnt_o, 2'b00};
                        wdata_d    = {rx_data, low_bytes};
                        word_cnt_d = word_cnt_o + 16'd1;
                        if (word_cnt_d == len) state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == csum) begin
                        state_d       = S_STRETCH;
                        sel_d         = 1'b0;
                        stretch_cnt_d = '0;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_STRETCH: begin
                if (stretch_cnt == STRETCH_LAST) begin
                    state_d    = S_IDLE;
                    core_rst_d = 1'b0;
                    busy_d     = 1'b0;
                end else begin
                    stretch_cnt_d = stretch_cnt + SW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state != S_IDLE && state != S_ERR && (rx_ferr || timeout)) state_d = S_ERR;

        // Single entry point into ERR so every error path drives the same outputs.
        if (state_d == S_ERR && state != S_ERR) begin
            err_d      = 1'b1;
            sel_d      = 1'b0;
            busy_d     = 1'b0;
            core_rst_d = 1'b1;
        end
    end

`ifdef UART_LOADER_TIMEOUT_EN
    localparam int            TO_CYC  = timeout_cycles(CLKS_PER_BIT);
    localparam int            TW      = $clog2(TO_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

    logic [TW-1:0] idle_cnt;
    logic          in_frame;

    assign in_frame = (state == S_LEN0) || (state == S_LEN1) || (state == S_DATA) || (state == S_CSUM);
    assign timeout  = in_frame && !rx_valid && (idle_cnt == TO_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i || !in_frame || rx_valid) idle_cnt <= '0;
        else if (idle_cnt != TO_LAST)       idle_cnt <= idle_cnt + TW'(1);
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_instr_loader.sv
// Directed self-checking bench for uart_instr_loader using a scaled-down baud rate (16 clocks/bit).
module tb_uart_instr_loader;

    localparam int CPB     = 16;
    localparam int STRETCH = 16;

    logic        clk, rst, rx;
    logic        req_o, we_o, sel_o, core_rst_o, busy_o, err_o;
    logic [31:0] addr_o, wdata_o;
    logic [15:0] word_cnt_o;

    int tests = 0;
    int fails = 0;
    int we_bad = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] img[0:1];

    uart_instr_loader #(
        .CLK_FREQ_HZ (1_600_000),
        .BAUD        (100_000),
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'h0),
        .RST_STRETCH (STRETCH)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .uart_rx_i  (rx),
        .req_o      (req_o),
        .we_o       (we_o),
        .addr_o     (addr_o),
        .wdata_o    (wdata_o),
        .sel_o      (sel_o),
        .core_rst_o (core_rst_o),
        .busy_o     (busy_o),
        .err_o      (err_o),
        .word_cnt_o (word_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM write monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (req_o === 1'b1) begin
            wr_addr.push_back(addr_o);
            wr_data.push_back(wdata_o);
        end
        if (we_o !== req_o) we_bad++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_cycles(CPB);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop = 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
        rx = 1'b1;
        wait_cycles(2);
    endtask

    // Sends a full frame of n words from img; flip corrupts the checksum byte.
    task automatic send_image(input int n, input logic [7:0] flip);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        send_byte(8'hA5);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                b  = img[w][8*k +: 8];
                cs = cs ^ b;
                send_byte(b);
            end
        end
        send_byte(cs ^ flip);
    endtask

    task automatic clear_writes();
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst core_rst", core_rst_o, 1);
        check("rst sel/busy/err/req", {sel_o, busy_o, err_o, req_o}, 0);
        check("rst addr", addr_o, 0);
        check("rst wdata", wdata_o, 0);
        check("rst word_cnt", word_cnt_o, 0);
        wait_cycles(STRETCH + 4);
        check("rst stretch release", core_rst_o, 0);

        // Good two-word frame.
        img[0] = 32'h1234_5678;
        img[1] = 32'hDEAD_BEEF;
        clear_writes();
        send_image(2, 8'h00);
        check("t1 core held after csum", core_rst_o, 1);
        wait_cycles(24);
        check("t1 core released", core_rst_o, 0);
        check("t1 write count", wr_addr.size(), 2);
        check("t1 addr0", wr_addr[0], 32'h0);
        check("t1 data0", wr_data[0], 32'h1234_5678);
        check("t1 addr1", wr_addr[1], 32'h4);
        check("t1 data1", wr_data[1], 32'hDEAD_BEEF);
        check("t1 err", err_o, 0);
        check("t1 word_cnt", word_cnt_o, 2);
        check("t1 sel/busy", {sel_o, busy_o}, 0);

        // Bad checksum, then recovery.
        clear_writes();
        send_image(2, 8'h01);
        wait_cycles(24);
        check("t2 err set", err_o, 1);
        check("t2 core held", core_rst_o, 1);
        check("t2 writes kept", wr_addr.size(), 2);
        check("t2 sel/busy", {sel_o, busy_o}, 0);
        clear_writes();
        send_image(2, 8'h00);
        wait_cycles(24);
        check("t2 err cleared", err_o, 0);
        check("t2 core released", core_rst_o, 0);
        check("t2 resend writes", wr_addr.size(), 2);

        // Zero-length frame, then oversize length 1025.
        clear_writes();
        send_image(0, 8'h00);
        wait_cycles(24);
        check("t3 N=0 writes", wr_addr.size(), 0);
        check("t3 N=0 word_cnt", word_cnt_o, 0);
        check("t3 N=0 core released", core_rst_o, 0);
        check("t3 N=0 err", err_o, 0);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h04);
        wait_cycles(4);
        check("t3 N=1025 err", err_o, 1);
        check("t3 N=1025 busy", busy_o, 0);
        check("t3 N=1025 core held", core_rst_o, 1);
        check("t3 N=1025 writes", wr_addr.size(), 0);

        // 0xA5 carried as payload is data, not a resync.
        img[0] = 32'hA5A5_A5A5;
        clear_writes();
        send_image(1, 8'h00);
        wait_cycles(24);
        check("a5 payload writes", wr_addr.size(), 1);
        check("a5 payload data", wr_data[0], 32'hA5A5_A5A5);
        check("a5 payload err", err_o, 0);
        check("a5 payload word_cnt", word_cnt_o, 1);

        // Framing error on the third data byte.
        clear_writes();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34, 1'b0);
        wait_cycles(4);
        check("t4 ferr err", err_o, 1);
        check("t4 ferr writes", wr_addr.size(), 0);
        check("t4 ferr core held", core_rst_o, 1);
        img[0] = 32'h1234_5678;
        send_image(2, 8'h00);
        wait_cycles(24);
        check("t4 recover core", core_rst_o, 0);

        // Short low glitch in IDLE must not swallow the following sync byte.
        rx = 1'b0;
        wait_cycles(4);
        rx = 1'b1;
        wait_cycles(6);
        send_byte(8'hA5);
        check("t4 glitch then sync busy", busy_o, 1);
        check("t4 glitch err", err_o, 0);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_cycles(24);
        check("t4 glitch frame done", {busy_o, core_rst_o}, 0);
        send_byte(8'h00, 1'b0);
        wait_cycles(4);
        check("t4 idle ferr ignored", {err_o, busy_o, core_rst_o}, 0);

        // Reset mid-frame after the second data byte.
        clear_writes();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h78);
        send_byte(8'h56);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        check("t5 core held after rst", core_rst_o, 1);
        check("t5 busy/sel/word_cnt", {busy_o, sel_o, word_cnt_o}, 0);
        send_byte(8'h34);
        send_byte(8'h12);
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        send_byte(8'hDE);
        send_byte(8'h2A);
        wait_cycles(24);
        check("t5 no writes", wr_addr.size(), 0);
        check("t5 core released", core_rst_o, 0);
        check("t5 err", err_o, 0);

        // Sync byte then silence.
        send_byte(8'hA5);
        check("t6 busy", busy_o, 1);
        check("t6 sel/core_rst", {sel_o, core_rst_o}, 2'b11);
        check("t6 word_cnt", word_cnt_o, 0);
        wait_cycles(170 * CPB);
`ifdef UART_LOADER_TIMEOUT_EN
        check("t6 timeout err", err_o, 1);
        check("t6 timeout busy", busy_o, 0);
`else
        check("t6 no timeout err", err_o, 0);
        check("t6 still busy", busy_o, 1);
`endif

        check("we equals req", we_bad, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
